load_store_unit: RTL and testbench

- Memory-side responder for the processor core's data interface. It takes the core's request (req/we/size/addr/wd) and issues a word-aligned request with byte enables to data memory.
- It holds the core with core_stall_o until memory answers, then returns the loaded value as a sign- or zero-extended 32-bit word.
- It sits between processor_core and the data memory in the top-level processor system.

---
 rtl/load_store_unit_pkg.sv | 17 +
 rtl/load_store_unit_data_align.sv | 48 ++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-side load/store path: access size codes and
// the load/store unit state encoding.
package load_store_unit_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_data_align.sv
// Combinational lane steering for the load/store unit: byte enables, store
// data replication, load extraction/extension and the alignment check.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] mem_rd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bad
);

  logic signed [7:0]  rd_byte;
  logic signed [15:0] rd_half;

  always_comb begin
    rd_byte = mem_rd[{addr_lo, 3'b000} +: 8];
    rd_half = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
    be      = 4'b0000;
    wdata   = 32'd0;
    rdata   = 32'd0;
    bad     = 1'b0;
    case (size)
      LDST_B, LDST_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{wd[7:0]}};
        rdata = (size == LDST_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      end
      LDST_H, LDST_HU: begin
        bad   = addr_lo[0];
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
        rdata = (size == LDST_H) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      end
      LDST_W: begin
        bad   = |addr_lo;
        be    = 4'b1111;
        wdata = wd;
        rdata = mem_rd;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core data request into a word-aligned memory access,
// stalls the core until memory answers (or times out) and returns the load value.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       size_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       size_sel;
  logic [1:0]       addr_lo_sel;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             bad;
  logic             timed_out;

  // In IDLE the aligner looks at the live request; afterwards at the latched one.
  always_comb begin
    size_sel    = (state == IDLE) ? core_size_i : size_q;
    addr_lo_sel = (state == IDLE) ? core_addr_i[1:0] : addr_lo_q;
  end

  lsu_data_align u_align (
    .size    (size_sel),
    .addr_lo (addr_lo_sel),
    .wd      (core_wd_i),
    .mem_rd  (mem_rd_i),
    .be      (be),
    .wdata   (wdata),
    .rdata   (rdata),
    .bad     (bad)
  );

  assign timed_out    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign core_stall_o = core_req_i && (state != DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      size_q     <= LDST_B;
      addr_lo_q  <= 2'd0;
      core_rd_o  <= 32'd0;
      core_err_o <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= 4'b0000;
      mem_addr_o <= 32'd0;
      mem_wd_o   <= 32'd0;
    end else begin
      core_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req_i) begin
            size_q    <= core_size_i;
            addr_lo_q <= core_addr_i[1:0];
            if (bad) begin
              state      <= DONE;
              core_err_o <= 1'b1;
              core_rd_o  <= 32'd0;
            end else begin
              state      <= WAIT;
              mem_req_o  <= 1'b1;
              mem_we_o   <= core_we_i;
              mem_be_o   <= be;
              mem_addr_o <= {core_addr_i[31:2], 2'b00};
              mem_wd_o   <= wdata;
            end
          end
        end
        WAIT: begin
          if (mem_ready_i || timed_out) begin
            state      <= DONE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0000;
            mem_addr_o <= 32'd0;
            mem_wd_o   <= 32'd0;
          end
          if (mem_ready_i) begin
            if (!mem_we_o) core_rd_o <= rdata;
          end else if (timed_out) begin
            core_err_o <= 1'b1;
            core_rd_o  <= 32'd0;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the core/memory handshake.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;

  logic [31:0] to_rd;
  logic        to_stall;
  logic        to_err;
  logic        to_mem_req;
  logic        to_mem_we;
  logic [3:0]  to_mem_be;
  logic [31:0] to_mem_addr;
  logic [31:0] to_mem_wd;

  int checks = 0;
  int passes = 0;
  logic [31:0] model_rd = 32'd0;

  typedef struct packed {
    logic [7:0]  n_stall;
    logic [7:0]  n_wait;
    logic        err;
    logic        err_after;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stable;
    logic [31:0] rd;
    logic [31:0] rd_idle;
  } res_t;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(to_rd), .core_stall_o(to_stall), .core_err_o(to_err),
    .mem_req_o(to_mem_req), .mem_we_o(to_mem_we), .mem_be_o(to_mem_be),
    .mem_addr_o(to_mem_addr), .mem_wd_o(to_mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The core must keep its request up while the primary unit is waiting on memory.
  always @(posedge clk)
    if (!rst) assert (!(mem_req && !core_req)) else $error("core request dropped during WAIT");

  // Reference: legality, lane steering and extension from plain arithmetic.
  function automatic res_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdv, input int waits,
                                 input logic [31:0] prev);
    res_t r;
    int off;
    logic [31:0] v;
    logic legal;
    r = '0;
    r.stable = 1'b1;
    off = int'(addr % 4);
    legal = (size == 0 || size == 4) || ((size == 1 || size == 5) && off % 2 == 0) ||
            (size == 2 && off == 0);
    if (!legal) begin
      r.n_stall = 8'd1;
      r.err = 1'b1;
      return r;
    end
    r.n_stall = 8'(waits + 2);
    r.n_wait  = 8'(waits + 1);
    r.we      = we;
    r.addr    = addr - 32'(off);
    if (size == 0 || size == 4) begin
      r.be = 4'(1 << off);
      r.wd = (wd & 32'hFF) * 32'h01010101;
      v = (rdv >> (8 * off)) & 32'hFF;
      if (size == 0 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 1 || size == 5) begin
      r.be = 4'(3 << off);
      r.wd = (wd & 32'hFFFF) * 32'h00010001;
      v = (rdv >> (8 * off)) & 32'hFFFF;
      if (size == 1 && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      r.be = 4'hF;
      r.wd = wd;
      v = rdv;
    end
    r.rd = we ? prev : v;
    r.rd_idle = r.rd;
    return r;
  endfunction

  // Drives one request on the primary unit and records what it did.
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdv, input int waits,
                           output res_t obs);
    int nw;
    logic done;
    obs = '0;
    obs.stable = 1'b1;
    nw = 0;
    done = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_rd = $urandom;
    mem_ready = 1'($urandom % 2);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (core_stall) obs.n_stall = obs.n_stall + 8'd1;
      if (mem_req) begin
        if (nw == 0) {obs.we, obs.be, obs.addr, obs.wd} = {mem_we, mem_be, mem_addr, mem_wd};
        else if ({mem_we, mem_be, mem_addr, mem_wd} !== {obs.we, obs.be, obs.addr, obs.wd})
          obs.stable = 1'b0;
        nw++;
        mem_ready = (nw == waits + 1);
        mem_rd = (nw == waits + 1) ? rdv : $urandom;
      end else if (!core_stall && cyc > 0) begin
        done = 1'b1;
        obs.err = core_err;
        obs.rd = core_rd;
        core_req = 1'b0;
        mem_ready = 1'($urandom % 2);
      end else begin
        mem_ready = 1'($urandom % 2);
      end
    end
    obs.n_wait = 8'(nw);
    @(negedge clk);
    obs.rd_idle = core_rd;
    obs.err_after = core_err;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    core_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_rd = 32'd0;
  endtask

  task automatic test_reset;
    core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = 32'd0; core_wd = 32'd0;
    mem_rd = 32'd0; mem_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_err, core_stall} !== '0)
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wd=%h rd=%h err=%b stall=%b want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, core_err, core_stall);
    else passes++;
    core_req = 1'b1;
    #1;
    checks++;
    if (core_stall !== 1'b1) $display("FAIL reset_stall_comb: got %b want 1", core_stall);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, to_mem_req, core_err} !== 3'b000)
      $display("FAIL reset_hold: got mem_req=%b to_mem_req=%b err=%b want 0", mem_req, to_mem_req, core_err);
    else passes++;
    core_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_rd = 32'd0;
  endtask

  task automatic test_store_word;
    res_t obs, exp;
    do_reset;
    exp = model(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, model_rd);
    do_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, obs);
    checks++;
    if (obs !== exp) $display("FAIL store_word: got %h want %h", obs, exp);
    else passes++;
    model_rd = exp.rd;
  endtask

  task automatic test_store_byte;
    res_t obs, exp;
    exp = model(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, model_rd);
    do_access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, obs);
    checks++;
    if (obs !== exp || obs.be !== 4'b1000 || obs.wd !== 32'hA5A5A5A5)
      $display("FAIL store_byte: got %h want %h", obs, exp);
    else passes++;
    model_rd = exp.rd;
  endtask

  task automatic test_loads;
    res_t obs, exp;
    logic [2:0]  sz [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad [4] = '{32'h3, 32'h3, 32'h2, 32'h0};
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h00007F01};
    for (int i = 0; i < 4; i++) begin
      exp = model(1'b0, sz[i], ad[i], 32'h0, 32'h80F07F01, 0, model_rd);
      do_access(1'b0, sz[i], ad[i], 32'h0, 32'h80F07F01, 0, obs);
      checks++;
      if (obs !== exp || obs.rd !== want[i])
        $display("FAIL load[%0d] size=%0d: got rd=%h (%h) want rd=%h (%h)", i, sz[i], obs.rd, obs, want[i], exp);
      else passes++;
      model_rd = exp.rd;
    end
  endtask

  task automatic test_wait_states;
    res_t obs, exp;
    do_reset;
    exp = model(1'b1, 3'd5, 32'h2222, 32'h1234ABCD, 32'h0, 5, model_rd);
    do_access(1'b1, 3'd5, 32'h2222, 32'h1234ABCD, 32'h0, 5, obs);
    checks++;
    if (obs !== exp || obs.n_stall !== 8'd7)
      $display("FAIL wait_states: got %h want %h", obs, exp);
    else passes++;
    model_rd = exp.rd;
  endtask

  task automatic test_misaligned;
    res_t obs, exp;
    logic [2:0]  sz [5] = '{3'd2, 3'd1, 3'd3, 3'd6, 3'd7};
    logic [31:0] ad [5] = '{32'h102, 32'h101, 32'h100, 32'h104, 32'h108};
    do_reset;
    exp = model(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 1, model_rd);
    do_access(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 1, obs);
    model_rd = exp.rd;
    for (int i = 0; i < 5; i++) begin
      exp = model(1'b0, sz[i], ad[i], 32'h0, 32'h55AA55AA, 0, model_rd);
      do_access(1'b0, sz[i], ad[i], 32'h0, 32'h55AA55AA, 0, obs);
      checks++;
      if (obs !== exp || obs.err !== 1'b1)
        $display("FAIL misaligned[%0d] size=%0d addr=%h: got %h want %h", i, sz[i], ad[i], obs, exp);
      else passes++;
      model_rd = exp.rd;
    end
  endtask

  task automatic test_random;
    res_t obs, exp;
    logic we;
    logic [2:0] sz;
    logic [31:0] a, d, r;
    int w;
    do_reset;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom % 2);
      sz = 3'($urandom % 8);
      a = $urandom; d = $urandom; r = $urandom;
      w = int'($urandom_range(3, 0));
      if ($urandom % 4 != 0) begin
        if (sz == 3'd2) a[1:0] = 2'b00;
        else if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
      end
      exp = model(we, sz, a, d, r, w, model_rd);
      do_access(we, sz, a, d, r, w, obs);
      checks++;
      if (obs !== exp)
        $display("FAIL random[%0d] we=%0d size=%0d addr=%h waits=%0d: got %h want %h", i, we, sz, a, w, obs, exp);
      else passes++;
      model_rd = exp.rd;
    end
  endtask

  task automatic test_timeout_and_reset;
    res_t obs, exp;
    int ns, nw;
    logic seen, terr;
    logic [31:0] trd;
    do_reset;
    exp = model(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, model_rd);
    do_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, obs);
    checks++;
    if (obs !== exp) $display("FAIL pre_timeout_load: got %h want %h", obs, exp);
    else passes++;
    model_rd = exp.rd;
    checks++;
    if (to_rd !== 32'h12345678) $display("FAIL timeout_unit_load: got %h want 12345678", to_rd);
    else passes++;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h80; mem_ready = 1'b0;
    ns = 0; nw = 0; seen = 1'b0; terr = 1'b0; trd = 32'hX;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (to_stall) ns++;
      if (to_mem_req) nw++;
      if (!to_stall) begin
        seen = 1'b1; terr = to_err; trd = to_rd;
      end
    end
    checks++;
    if ({seen, ns, nw, terr, trd} !== {1'b1, 32'd5, 32'd4, 1'b1, 32'h0})
      $display("FAIL timeout: got done=%b stall=%0d wait=%0d err=%b rd=%h want done=1 stall=5 wait=4 err=1 rd=0",
               seen, ns, nw, terr, trd);
    else passes++;
    checks++;
    if (mem_req !== 1'b1) $display("FAIL still_waiting: got mem_req=%b want 1", mem_req);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_be, mem_addr, core_rd, to_mem_req, to_err} !== '0)
      $display("FAIL reset_mid_wait: got mem_req=%b be=%b addr=%h rd=%h to_req=%b to_err=%b want 0",
               mem_req, mem_be, mem_addr, core_rd, to_mem_req, to_err);
    else passes++;
    core_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_rd = 32'd0;
    exp = model(1'b0, 3'd4, 32'h21, 32'h0, 32'hAABBCCDD, 1, model_rd);
    do_access(1'b0, 3'd4, 32'h21, 32'h0, 32'hAABBCCDD, 1, obs);
    checks++;
    if (obs !== exp || obs.rd !== 32'h000000CC)
      $display("FAIL after_reset_load: got %h want %h", obs, exp);
    else passes++;
    model_rd = exp.rd;
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_store_byte;
    test_loads;
    test_wait_states;
    test_misaligned;
    test_random;
    test_timeout_and_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
